// File: rtl/diff_accum_tx.sv
// Block averager for TDC difference samples: sums 2^LOG2_N samples, floors the mean,
// and frames each average as SYNC, seq, avg[23:16], avg[15:8], avg[7:0] on a byte stream.
module diff_accum_tx #(
    parameter int          LOG2_N    = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          DATA_W    = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_dval,
    input  logic                     clear,
    output logic signed [DATA_W-1:0] avg_out,
    output logic                     avg_valid,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     overrun
);

    localparam int ACC_W = DATA_W + LOG2_N;

    typedef enum logic [2:0] {IDLE, SYNC, SEQ, B2, B1, B0} state_t;

    state_t                   state, state_nxt;
    logic                     dval_p0;
    logic signed [ACC_W-1:0]  acc_p0;
    logic signed [ACC_W-1:0]  sum;
    logic [LOG2_N-1:0]        cnt_p0;
    logic [7:0]               seq;
    logic signed [23:0]       pkt_avg;
    logic signed [DATA_W-1:0] avg_new;
    logic                     accept;
    logic                     complete;
    logic                     hs;
    logic                     load;

    // Arithmetic shift floors toward -inf, which is the intended average for negative sums.
    function automatic logic signed [DATA_W-1:0] avg_shift(input logic signed [ACC_W-1:0] s);
        return DATA_W'(s >>> LOG2_N);
    endfunction

    function automatic logic signed [23:0] sext24(input logic signed [DATA_W-1:0] v);
        return 24'(v);
    endfunction

    assign accept   = in_dval & ~dval_p0;
    assign sum      = acc_p0 + ACC_W'(in_data);
    assign avg_new  = avg_shift(sum);
    assign complete = accept & ~clear & (cnt_p0 == '1);
    assign tx_valid = (state != IDLE);
    assign hs       = tx_valid & tx_ready;
    // A new packet may start from IDLE or chain straight off the final byte's handshake.
    assign load     = complete & ((state == IDLE) | ((state == B0) & hs));

    // Stage p0: edge detect and accumulation; the completing sample produces the average.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dval_p0   <= 1'b0;
            acc_p0    <= '0;
            cnt_p0    <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            dval_p0   <= in_dval;
            avg_valid <= 1'b0;
            if (clear) begin
                acc_p0  <= '0;
                cnt_p0  <= '0;
                overrun <= 1'b0;
            end else if (accept) begin
                if (cnt_p0 == '1) begin
                    acc_p0    <= '0;
                    cnt_p0    <= '0;
                    avg_out   <= avg_new;
                    avg_valid <= 1'b1;
                    if (!load) overrun <= 1'b1;
                end else begin
                    acc_p0 <= sum;
                    cnt_p0 <= cnt_p0 + 1'b1;
                end
            end
        end
    end

    // Packer: snapshot taken on load so the packet in flight never changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            seq     <= 8'h00;
            pkt_avg <= '0;
        end else begin
            state <= state_nxt;
            if (load) pkt_avg <= sext24(avg_new);
            if ((state == B0) && hs) seq <= seq + 8'h01;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_data   = 8'h00;
        case (state)
            IDLE: if (load) state_nxt = SYNC;
            SYNC: begin
                tx_data = SYNC_BYTE;
                if (hs) state_nxt = SEQ;
            end
            SEQ: begin
                tx_data = seq;
                if (hs) state_nxt = B2;
            end
            B2: begin
                tx_data = pkt_avg[23:16];
                if (hs) state_nxt = B1;
            end
            B1: begin
                tx_data = pkt_avg[15:8];
                if (hs) state_nxt = B0;
            end
            B0: begin
                tx_data = pkt_avg[7:0];
                if (hs) state_nxt = load ? SYNC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/diff_accum_tx.md
# diff_accum_tx

Downstream stage of the TDC difference block in the DSFD pipeline. Accepts signed 20-bit difference samples, averages each block of 2^LOG2_N samples (sum plus arithmetic shift), and serialises every average into a 5-byte packet over a valid/ready byte interface toward the UART transmitter. Gives host-side noise and offset measurements a decimated, framed data stream.

## Interface
- LOG2_N, 4, log2 of samples per average (1..8)
- SYNC_BYTE, 8'hA5, first byte of every packet
- clk  in  1  system clock
- rst  in  1  reset rst, asynchronous, active-low
- in_data  in  20  signed two's-complement difference sample; stable while in_dval high
- in_dval  in  1  sample strobe; the sample is taken on its rising edge
- clear  in  1  synchronous; discards the partial accumulation and clears overrun
- avg_out  out  20  last completed average, signed
- avg_valid  out  1  one-cycle pulse when avg_out updates
- tx_data  out  8  packet byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  consumer accepts tx_data when tx_valid & tx_ready
- overrun  out  1  sticky; an average was dropped because the packer was busy

## Operation
- Edge detect: dval_q <= in_dval each cycle; accept = in_dval & ~dval_q. A level held high counts as one sample.
- Accumulator: signed, width 20+LOG2_N; in_data sign-extended. cnt (LOG2_N bits) counts accepted samples.
- On accept with cnt < 2^LOG2_N-1: acc <= acc + x, cnt <= cnt+1.
- On accept with cnt = 2^LOG2_N-1 (block complete): s = acc + x; avg_out <= s >>> LOG2_N (arithmetic shift, floor toward -inf); avg_valid <= 1; acc <= 0; cnt <= 0.
- No overflow is possible: the accumulator width covers the worst case (2^LOG2_N × -2^19).
- Packer FSM states: IDLE, SYNC, SEQ, B2, B1, B0.
  - IDLE: on block complete, snapshot avg (sign-extended to 24 bits) and seq, go to SYNC.
  - SYNC sends SYNC_BYTE; SEQ sends seq[7:0]; B2 sends avg24[23:16]; B1 sends avg24[15:8]; B0 sends avg24[7:0]. Each state advances only on tx_valid & tx_ready. B0 handshake returns to IDLE and increments seq (8-bit, wraps FF->00).
  - tx_valid = (state != IDLE). tx_data holds while tx_ready is low.
- Block completes while the packer is busy: avg_out/avg_valid still update, the packet is not loaded, overrun <= 1. The packet in flight keeps its snapshot.
- Block completes in the same cycle as the B0 handshake: the new packet loads directly into SYNC, with no IDLE cycle and no overrun.
- clear: acc <= 0, cnt <= 0, overrun <= 0. Does not abort a packet in flight and does not touch seq or avg_out. If clear and accept occur in the same cycle, clear wins and the sample is discarded.
- Reset: acc, cnt, dval_q, seq, avg_out all 0; avg_valid 0; overrun 0; state IDLE; tx_valid 0; tx_data 0.

## Timing
- Accept detected in cycle k (in_dval rises before edge k). Accumulator updates at edge k.
- Completing sample at edge k: avg_out, avg_valid and state=SYNC all take effect after edge k. tx_valid is high in cycle k+1.
- Minimum packet duration is 5 cycles with tx_ready held high. Back-to-back packets need blocks no closer than 5 cycles apart.
- in_dval must be low for at least 1 cycle between samples.
- Reset deassertion mid-packet is not special-cased: assertion of rst aborts immediately to IDLE.

## Test plan
- LOG2_N=4. Strobe 16 samples 0..15, tx_ready=1 -> avg_valid pulse once, avg_out=7. Bytes A5,00,00,00,07 on 5 consecutive cycles.
- 16 samples of -1 (20'hFFFFF) -> avg_out=20'hFFFFF. Packet A5,01,FF,FF,FF (seq incremented).
- 16 samples of 20'h80000 (min) -> avg_out=20'h80000, no wrap. 16 samples of 20'h7FFFF -> avg_out=20'h7FFFF.
- tx_ready low during SEQ for 10 cycles -> tx_data stays at seq, no byte lost or duplicated. A second block completing meanwhile -> overrun=1, avg_out updated, packet bytes unchanged. clear -> overrun=0.
- in_dval held high 50 cycles -> counted as 1 sample. Clear asserted on a rising edge of in_dval -> sample dropped, cnt=0.
- Block completing on the B0 handshake cycle -> next cycle tx_data=A5, overrun stays 0. Drive 256 packets -> seq wraps FF->00. rst pulse mid-packet -> tx_valid=0 and all outputs at reset values immediately.
